vpd_responder: RTL and testbench

- Responder end of the cfg_vpd_* request/done handshake driven by the host configuration interface.
- Answers VPD reads and writes from two regions: a read-only identity ROM and a writable 64-word scratch store.
- Unmapped or illegal requests raise an error pulse.
- Instantiated inside the flash/VPD wrapper in place of the tie-off assignments; runs on clock_tlx.

---
 rtl/vpd_pkg.sv | 19 +
 rtl/vpd_if.sv | 23 ++
 rtl/vpd_scratch_ram.sv | 25 ++
 rtl/vpd_responder.sv | 147 ++++++++++++++
 tb/tb_vpd_responder.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vpd_pkg.sv
// Shared constants and state encoding for the VPD responder.
// Region bounds are byte addresses on the 15-bit cfg_vpd_addr bus.
package vpd_pkg;

    localparam logic [14:0] ROM_BASE  = 15'h000;
    localparam logic [14:0] SCR_BASE  = 15'h100;
    localparam logic [14:0] MAP_END   = 15'h200;
    localparam int          SCR_WORDS = 64;
    localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_ACCESS    = 3'd2,
        ST_RESP      = 3'd3,
        ST_WAIT_DROP = 3'd4
    } vpd_state_e;

endpackage

// File: rtl/vpd_if.sv
// cfg_vpd request/done handshake between the host configuration interface
// (master) and the VPD responder (slave).
interface vpd_if;

    logic [14:0] cfg_vpd_addr;
    logic        cfg_vpd_wren;
    logic [31:0] cfg_vpd_wdata;
    logic        cfg_vpd_rden;
    logic [31:0] vpd_cfg_rdata;
    logic        vpd_cfg_done;
    logic        vpd_err_unimplemented_addr;

    modport master (
        output cfg_vpd_addr, cfg_vpd_wren, cfg_vpd_wdata, cfg_vpd_rden,
        input  vpd_cfg_rdata, vpd_cfg_done, vpd_err_unimplemented_addr
    );

    modport slave (
        input  cfg_vpd_addr, cfg_vpd_wren, cfg_vpd_wdata, cfg_vpd_rden,
        output vpd_cfg_rdata, vpd_cfg_done, vpd_err_unimplemented_addr
    );

endinterface

// File: rtl/vpd_scratch_ram.sv
// Single-port scratch store with a registered read; the one write port is
// shared between the post-reset clear sweep and host writes.
module vpd_scratch_ram
    import vpd_pkg::*;
#(
    parameter int WORDS = SCR_WORDS,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/vpd_responder.sv
// VPD responder: answers cfg_vpd reads/writes from an identity ROM and a
// 64-word scratch store, flagging unmapped or malformed requests.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   INIT       | clearing scratch word clr_cnt; requests not sampled
//   IDLE       | waiting for rden|wren; latches the request
//   ACCESS     | scratch read/write, ROM lookup, legality resolved
//   RESP       | done pulse; rdata/err driven
//   WAIT_DROP  | waiting for the requester to release rden/wren
module vpd_responder
    import vpd_pkg::*;
#(
    parameter logic [15:0] VENDOR_ID = 16'h1014,
    parameter logic [15:0] DEVICE_ID = 16'h062B,
    parameter logic [31:0] REVISION  = 32'h0000_0001,
    parameter string       INIT_FILE = ""
) (
    input logic  clock,
    input logic  reset,
    vpd_if.slave vpd
);

    localparam logic [2:0] INIT      = ST_INIT;
    localparam logic [2:0] IDLE      = ST_IDLE;
    localparam logic [2:0] ACCESS    = ST_ACCESS;
    localparam logic [2:0] RESP      = ST_RESP;
    localparam logic [2:0] WAIT_DROP = ST_WAIT_DROP;

    logic [2:0]  state;
    logic [5:0]  clr_cnt;
    logic [14:0] addr_q;
    logic [31:0] wdata_q;
    logic        rd_q;
    logic        wr_q;
    logic        illegal_q;
    logic [31:0] rom_q;
    logic [31:0] rdata_hold;

    logic        is_scr;
    logic        illegal_c;
    logic [31:0] rom_word;
    logic [31:0] rom_file_word;
    logic        ram_we;
    logic [5:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_q;
    logic [31:0] resp_word;
    logic [31:0] rdata_out;

    always_comb begin
        is_scr    = (addr_q >= SCR_BASE) && (addr_q < MAP_END);
        illegal_c = (rd_q && wr_q) || (addr_q >= MAP_END) || (addr_q[1:0] != 2'b00);
    end

    assign rom_file_word = '0;

    always_comb begin
        case (addr_q[7:2])
            6'd0:    rom_word = {DEVICE_ID, VENDOR_ID};
            6'd1:    rom_word = REVISION;
            default: rom_word = rom_file_word;
        endcase
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = addr_q[7:2];
        ram_wdata = wdata_q;
        if (state == INIT) begin
            ram_we    = 1'b1;
            ram_addr  = clr_cnt;
            ram_wdata = '0;
        end else if (state == ACCESS && wr_q && !illegal_c && is_scr) begin
            ram_we = 1'b1;
        end
    end

    vpd_scratch_ram #(.WORDS(SCR_WORDS)) u_scratch (
        .clock (clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

    // Writes leave rdata untouched; reads and errors present the new word in the done cycle.
    always_comb begin
        resp_word = illegal_q ? ERR_RDATA : (is_scr ? ram_q : rom_q);
        rdata_out = rdata_hold;
        if (state == RESP && (rd_q || illegal_q)) begin
            rdata_out = resp_word;
        end
    end

    assign vpd.vpd_cfg_rdata              = rdata_out;
    assign vpd.vpd_cfg_done               = (state == RESP);
    assign vpd.vpd_err_unimplemented_addr = (state == RESP) && illegal_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= INIT;
            clr_cnt    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            illegal_q  <= 1'b0;
            rom_q      <= '0;
            rdata_hold <= '0;
        end else begin
            case (state)
                INIT: begin
                    clr_cnt <= clr_cnt + 6'd1;
                    if (clr_cnt == 6'(SCR_WORDS - 1)) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (vpd.cfg_vpd_rden || vpd.cfg_vpd_wren) begin
                        addr_q  <= vpd.cfg_vpd_addr;
                        wdata_q <= vpd.cfg_vpd_wdata;
                        rd_q    <= vpd.cfg_vpd_rden;
                        wr_q    <= vpd.cfg_vpd_wren;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    rom_q     <= rom_word;
                    illegal_q <= illegal_c;
                    state     <= RESP;
                end
                RESP: begin
                    rdata_hold <= rdata_out;
                    state      <= WAIT_DROP;
                end
                WAIT_DROP: begin
                    if (!vpd.cfg_vpd_rden && !vpd.cfg_vpd_wren) begin
                        state <= IDLE;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_vpd_responder.sv
// Bench for vpd_responder: protocol-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vpd_responder;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    vpd_if vpd ();

    vpd_responder dut (
        .clock (clock),
        .reset (reset),
        .vpd   (vpd)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int first_done_cyc = -1;

    // literal expectations from the stimulus process, checked by the compare process
    string       lit_nm  [$];
    logic [31:0] lit_act [$];
    logic [31:0] lit_req [$];

    // reference model state
    logic [31:0] m_scr [64];
    int          m_phase;      // 0 clearing, 1 ready, 2 accepted, 3 responding, 4 awaiting release
    int          m_init_left;
    logic        m_rd, m_wr;
    logic [14:0] m_addr;
    logic [31:0] m_wdata;
    logic        exp_done, exp_err;
    logic [31:0] exp_rdata;

    function automatic logic [31:0] rom_model(input int idx);
        if (idx == 0) return 32'h062B_1014;
        if (idx == 1) return 32'h0000_0001;
        return 32'h0;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, req);
        end
    endtask

    task automatic expect_lit(input string nm, input logic [31:0] act, input logic [31:0] req);
        lit_nm.push_back(nm);
        lit_act.push_back(act);
        lit_req.push_back(req);
    endtask

    task automatic model_respond();
        int idx;
        bit illegal;
        illegal = (m_rd && m_wr) || (int'(m_addr) >= 512) || (int'(m_addr) % 4 != 0);
        exp_done = 1'b1;
        if (illegal) begin
            exp_err   = 1'b1;
            exp_rdata = 32'hFFFF_FFFF;
        end else if (m_wr) begin
            if (int'(m_addr) >= 256) begin
                idx = (int'(m_addr) - 256) / 4;
                m_scr[idx] = m_wdata;
            end
        end else if (int'(m_addr) < 256) begin
            exp_rdata = rom_model(int'(m_addr) / 4);
        end else begin
            idx = (int'(m_addr) - 256) / 4;
            exp_rdata = m_scr[idx];
        end
    endtask

    always @(posedge clock) begin : compare
        logic s_rd, s_wr;
        s_rd = vpd.cfg_vpd_rden;
        s_wr = vpd.cfg_vpd_wren;
        if (reset) begin
            m_phase     = 0;
            m_init_left = 64;
            exp_done    = 1'b0;
            exp_err     = 1'b0;
            exp_rdata   = 32'h0;
            cyc         = 0;
            for (int i = 0; i < 64; i++) m_scr[i] = 32'h0;
        end else begin
            cyc++;
            exp_done = 1'b0;
            exp_err  = 1'b0;
            case (m_phase)
                0: begin
                    m_init_left--;
                    if (m_init_left == 0) m_phase = 1;
                end
                1: if (s_rd || s_wr) begin
                    m_rd    = s_rd;
                    m_wr    = s_wr;
                    m_addr  = vpd.cfg_vpd_addr;
                    m_wdata = vpd.cfg_vpd_wdata;
                    m_phase = 2;
                end
                2: begin
                    model_respond();
                    m_phase = 3;
                end
                3: m_phase = 4;
                default: if (!s_rd && !s_wr) m_phase = 1;
            endcase
        end
        #1;
        check("done", 32'(vpd.vpd_cfg_done), 32'(exp_done));
        check("err", 32'(vpd.vpd_err_unimplemented_addr), 32'(exp_err));
        check("rdata", vpd.vpd_cfg_rdata, exp_rdata);
        if (vpd.vpd_cfg_done && first_done_cyc < 0) first_done_cyc = cyc;
        while (lit_nm.size() > 0) begin
            check(lit_nm.pop_front(), lit_act.pop_front(), lit_req.pop_front());
        end
    end

    // Caller is at a negedge; returns at a negedge with the FSM idle again.
    task automatic req(input logic rd, input logic wr, input logic [14:0] addr,
                       input logic [31:0] wd, input int hold_after, input bit early_drop,
                       input bit rst_pulse, output logic [31:0] r_data, output logic r_err,
                       output int r_lat, output int r_extra);
        int req_cyc;
        int n;
        bit seen;
        vpd.cfg_vpd_rden  = rd;
        vpd.cfg_vpd_wren  = wr;
        vpd.cfg_vpd_addr  = addr;
        vpd.cfg_vpd_wdata = wd;
        req_cyc = cyc;
        seen    = 0;
        n       = 0;
        r_data  = 32'h0;
        r_err   = 1'b0;
        r_lat   = -1;
        r_extra = 0;
        while (!seen && n < 400) begin
            @(negedge clock);
            n++;
            if (early_drop && n == 1) begin
                vpd.cfg_vpd_rden = 1'b0;
                vpd.cfg_vpd_wren = 1'b0;
            end
            if (rst_pulse && n == 1) reset = 1'b1;
            if (rst_pulse && n == 2) reset = 1'b0;
            if (vpd.vpd_cfg_done) begin
                seen   = 1;
                r_data = vpd.vpd_cfg_rdata;
                r_err  = vpd.vpd_err_unimplemented_addr;
                r_lat  = cyc - req_cyc;
            end
        end
        expect_lit("done_seen", 32'(seen), 32'd1);
        repeat (hold_after) begin
            @(negedge clock);
            if (vpd.vpd_cfg_done) r_extra++;
        end
        vpd.cfg_vpd_rden = 1'b0;
        vpd.cfg_vpd_wren = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] rv;
        logic        ev;
        int          lat, extra, n, cnt;
        logic [14:0] a;
        int          sel, kind;

        vpd.cfg_vpd_addr  = 15'h0;
        vpd.cfg_vpd_wdata = 32'h0;
        vpd.cfg_vpd_wren  = 1'b0;
        vpd.cfg_vpd_rden  = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // ID read held across the clear sweep
        n = 0;
        while (!vpd.vpd_cfg_done && n < 200) begin
            @(negedge clock);
            n++;
        end
        expect_lit("first_done_cyc", 32'(first_done_cyc), 32'd66);
        expect_lit("id_rdata", vpd.vpd_cfg_rdata, 32'h062B_1014);
        expect_lit("id_err", 32'(vpd.vpd_err_unimplemented_addr), 32'd0);
        vpd.cfg_vpd_rden = 1'b0;
        repeat (2) @(negedge clock);

        // scratch write then read-back
        req(1'b0, 1'b1, 15'h104, 32'hDEAD_BEEF, 0, 0, 0, rv, ev, lat, extra);
        req(1'b1, 1'b0, 15'h104, 32'h0, 0, 0, 0, rv, ev, lat, extra);
        expect_lit("scr_rdata", rv, 32'hDEAD_BEEF);
        expect_lit("scr_latency", 32'(lat), 32'd2);
        req(1'b1, 1'b0, 15'h108, 32'h0, 0, 0, 0, rv, ev, lat, extra);
        expect_lit("scr_cleared", rv, 32'h0);

        // illegal requests
        req(1'b1, 1'b0, 15'h200, 32'h0, 0, 0, 0, rv, ev, lat, extra);
        expect_lit("err_hi_err", 32'(ev), 32'd1);
        expect_lit("err_hi_rdata", rv, 32'hFFFF_FFFF);
        req(1'b1, 1'b0, 15'h102, 32'h0, 0, 0, 0, rv, ev, lat, extra);
        expect_lit("err_unal_err", 32'(ev), 32'd1);
        expect_lit("err_unal_rdata", rv, 32'hFFFF_FFFF);
        req(1'b1, 1'b1, 15'h100, 32'h5555_AAAA, 0, 0, 0, rv, ev, lat, extra);
        expect_lit("err_both_err", 32'(ev), 32'd1);
        expect_lit("err_both_rdata", rv, 32'hFFFF_FFFF);
        req(1'b1, 1'b0, 15'h100, 32'h0, 0, 0, 0, rv, ev, lat, extra);
        expect_lit("both_no_write", rv, 32'h0);

        // write to ROM discarded
        req(1'b0, 1'b1, 15'h004, 32'h1234_5678, 0, 0, 0, rv, ev, lat, extra);
        expect_lit("rom_wr_err", 32'(ev), 32'd0);
        req(1'b1, 1'b0, 15'h004, 32'h0, 0, 0, 0, rv, ev, lat, extra);
        expect_lit("rom_rev", rv, 32'h0000_0001);
        expect_lit("rom_rev_err", 32'(ev), 32'd0);

        // held request serviced once
        req(1'b1, 1'b0, 15'h000, 32'h0, 10, 0, 0, rv, ev, lat, extra);
        expect_lit("held_extra_done", 32'(extra), 32'd0);
        expect_lit("held_rdata", rv, 32'h062B_1014);

        // reset re-clears scratch
        req(1'b0, 1'b1, 15'h1FC, 32'hA5A5_A5A5, 0, 0, 0, rv, ev, lat, extra);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        cnt = 0;
        repeat (64) begin
            @(negedge clock);
            if (vpd.vpd_cfg_done) cnt++;
        end
        expect_lit("init_no_done", 32'(cnt), 32'd0);
        req(1'b1, 1'b0, 15'h1FC, 32'h0, 0, 0, 0, rv, ev, lat, extra);
        expect_lit("reset_cleared", rv, 32'h0);

        // randomized traffic, checked by the per-cycle model
        for (int i = 0; i < 200; i++) begin
            bit ed, rp;
            kind = int'($urandom_range(0, 9));
            sel  = int'($urandom_range(0, 3));
            case (sel)
                0: a = 15'({$urandom_range(0, 63), 2'b00});
                1: a = 15'h100 + 15'({$urandom_range(0, 7), 2'b00});
                2: a = 15'($urandom);
                default: a = 15'($urandom_range(0, 511));
            endcase
            rp = ($urandom_range(0, 49) == 0);
            ed = !rp && ($urandom_range(0, 5) == 0);
            req(kind < 5 || kind == 9, kind >= 5, a, $urandom,
                int'($urandom_range(0, 3)), ed, rp, rv, ev, lat, extra);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
